// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU bus slave with mirrored RAM, fixed vectors, reloadable IRQ timer.
// Optional NMI pulse generator at $4024, enabled by defining CPU_BUS_RESPONDER_NMI_EN.
module cpu_bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] NMI_VEC   = 16'h2000,
  parameter logic [15:0] IRQ_VEC   = 16'h2000
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic        R_nW,
  input  logic [7:0]  Data_bus_out,
  output logic [7:0]  Data_bus_in,
  output logic        irq,
  output logic        nmi
);
  logic [7:0]  ram [0:(1<<RAM_AW)-1];
  logic [7:0]  tlo, thi, nmi_rd, vec_byte;
  logic [2:0]  ctrl;
  logic [15:0] cnt, vec;
  logic        pend, pend_next, expire, wr, ram_sel, wr_ctrl, rd_stat, ie_next;
  assign wr        = ~R_nW;
  assign ram_sel   = Addr_bus[15:13] == 3'b000;
  assign wr_ctrl   = wr && Addr_bus == 16'h4022;
  assign rd_stat   = R_nW && Addr_bus == 16'h4023;
  // A CTRL write owns the counter on its edge, so no expiry is seen then.
  assign expire    = ctrl[0] && cnt == 16'h0000 && !wr_ctrl;
  assign pend_next = expire || (pend && !rd_stat);
  assign ie_next   = wr_ctrl ? Data_bus_out[2] : ctrl[2];
  assign vec       = Addr_bus[2:1] == 2'b01 ? NMI_VEC : Addr_bus[2:1] == 2'b10 ? RESET_VEC : IRQ_VEC;
  assign vec_byte  = Addr_bus[0] ? vec[15:8] : vec[7:0];
  assign Data_bus_in = ram_sel                            ? ram[Addr_bus[RAM_AW-1:0]] :
                       Addr_bus == 16'h4020               ? tlo :
                       Addr_bus == 16'h4021               ? thi :
                       Addr_bus == 16'h4022               ? {5'b0, ctrl} :
                       Addr_bus == 16'h4023               ? {pend, 7'b0} :
                       Addr_bus == 16'h4024               ? nmi_rd :
                       Addr_bus >= 16'hFFFA               ? vec_byte : 8'h00;
  always_ff @(posedge clk_ph1)
    if (wr && ram_sel) ram[Addr_bus[RAM_AW-1:0]] <= Data_bus_out;
  always_ff @(posedge clk_ph1 or negedge rst)
    if (!rst) begin
      tlo  <= 8'h00;
      thi  <= 8'h00;
      ctrl <= 3'b000;
      cnt  <= 16'h0000;
      pend <= 1'b0;
      irq  <= 1'b1;
    end else begin
      if (wr && Addr_bus == 16'h4020) tlo <= Data_bus_out;
      if (wr && Addr_bus == 16'h4021) thi <= Data_bus_out;
      if (wr_ctrl) begin
        ctrl <= Data_bus_out[2:0];
        if (Data_bus_out[0]) cnt <= {thi, tlo};
      end else if (ctrl[0]) begin
        if (cnt != 16'h0000) cnt <= cnt - 16'h0001;
        else if (ctrl[1]) cnt <= {thi, tlo};
        else ctrl[0] <= 1'b0;
      end
      pend <= pend_next;
      irq  <= ~(pend_next && ie_next);
    end
`ifdef CPU_BUS_RESPONDER_NMI_EN
  logic [3:0] nmi_cnt;
  logic       wr_nmi;
  assign wr_nmi = wr && Addr_bus == 16'h4024;
  assign nmi_rd = {7'b0, ~nmi};
  // nmi goes low on the trigger edge and rises on the edge that empties the count.
  always_ff @(posedge clk_ph1 or negedge rst)
    if (!rst) begin
      nmi_cnt <= 4'd0;
      nmi     <= 1'b1;
    end else begin
      nmi_cnt <= wr_nmi ? 4'd8 : nmi_cnt - {3'b0, nmi_cnt != 4'd0};
      nmi     <= !(wr_nmi || nmi_cnt > 4'd1);
    end
`else
  assign nmi    = 1'b1;
  assign nmi_rd = 8'h00;
`endif
endmodule
